// File: rtl/reset_sequencer.sv
// reset_sequencer: initiator side of the ILI9341 RESX hardware-reset handshake.
// Define RST_SEQ_TIMEOUT_EN to add a watchdog on the WAIT states (ERROR on expiry).
module reset_sequencer #(
    parameter int unsigned PULSES      = 1,
    parameter int unsigned SETTLE_CYC  = 800_000,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_reset_ena,
    output logic o_reset_val,
    input  logic i_reset_sent,
    output logic o_busy,
    output logic o_done,
    output logic o_ready,
    output logic o_error
);

    localparam int unsigned PW = $clog2(PULSES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam logic [PW-1:0] PULSES_W    = PW'(PULSES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LOW,
        WAIT_LOW,
        REQ_HIGH,
        WAIT_HIGH,
        SETTLE,
        DONE,
        ERROR
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pair_cnt;
    logic [PW-1:0] pair_nxt;
    logic [SW-1:0] settle_cnt;
    logic          ready_q;
    logic          start_accept;
    logic          settle_last;
    logic          wd_expired;

    assign start_accept = i_start && !o_busy;
    assign settle_last  = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
    assign pair_nxt     = pair_cnt + PW'(1);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (i_start)             state_nxt = REQ_LOW;
                else if (state == DONE)  state_nxt = IDLE;
            end
            REQ_LOW:  state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (i_reset_sent)        state_nxt = REQ_HIGH;
                else if (wd_expired)     state_nxt = ERROR;
            end
            REQ_HIGH: state_nxt = WAIT_HIGH;
            WAIT_HIGH: begin
                if (i_reset_sent)        state_nxt = (pair_nxt < PULSES_W) ? REQ_LOW : SETTLE;
                else if (wd_expired)     state_nxt = ERROR;
            end
            SETTLE: begin
                if (settle_last)         state_nxt = DONE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            settle_cnt <= '0;
            ready_q    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_accept)
                pair_cnt <= '0;
            else if (state == WAIT_HIGH && i_reset_sent)
                pair_cnt <= pair_nxt;

            // Counts only while settling; the terminal value SETTLE_CYC still fits, so no wrap.
            if (state == SETTLE)
                settle_cnt <= settle_cnt + SW'(1);
            else
                settle_cnt <= '0;

            if (start_accept)
                ready_q <= 1'b0;
            else if (settle_last)
                ready_q <= 1'b1;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

    logic [WW-1:0] wd_cnt;
    logic          in_wait;

    assign in_wait = (state == WAIT_LOW) || (state == WAIT_HIGH);

    // Each WAIT state is preceded by a REQ state, so clearing outside WAIT clears on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (in_wait)
            wd_cnt <= wd_cnt + WW'(1);
        else
            wd_cnt <= '0;
    end

    assign wd_expired = in_wait && (wd_cnt == WD_LAST);
    assign o_error    = (state == ERROR);
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYC;
    assign wd_expired     = 1'b0;
    assign o_error        = 1'b0;
`endif

    assign o_reset_ena = (state == REQ_LOW) || (state == REQ_HIGH);
    assign o_reset_val = !((state == REQ_LOW) || (state == WAIT_LOW));
    assign o_busy      = !((state == IDLE) || (state == DONE) || (state == ERROR));
    assign o_done      = (state == DONE);
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: two instances (PULSES=1 and PULSES=2), a timed
// responder model and a scoreboard of expected strobes and done pulses.
module tb_reset_sequencer;

    localparam int SETTLE  = 10;
    localparam int TIMEOUT = 20;

    typedef struct {
        int dut;
        bit is_done;
        bit val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start [2];
    logic sent  [2];
    logic ena   [2];
    logic val   [2];
    logic busy  [2];
    logic done  [2];
    logic ready [2];
    logic err   [2];

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt [2] = '{0, 0};
    int  spur_at  [2] = '{-1, -1};
    int  resp_dly = 5;
    bit  resp_en  = 1'b1;
    ev_t q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer #(.PULSES(1), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut_a (
        .clk(clk), .rst(rst), .i_start(start[0]), .o_reset_ena(ena[0]), .o_reset_val(val[0]),
        .i_reset_sent(sent[0]), .o_busy(busy[0]), .o_done(done[0]), .o_ready(ready[0]),
        .o_error(err[0])
    );

    reset_sequencer #(.PULSES(2), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut_b (
        .clk(clk), .rst(rst), .i_start(start[1]), .o_reset_ena(ena[1]), .o_reset_val(val[1]),
        .i_reset_sent(sent[1]), .o_busy(busy[1]), .o_done(done[1]), .o_ready(ready[1]),
        .o_error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic push(input int d, input bit is_done, input bit v, input int c);
        ev_t e;
        e.dut = d;
        e.is_done = is_done;
        e.val = v;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic wait_done(input int d, input int target);
        int k;
        k = 0;
        while (done_cnt[d] < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", done_cnt[d], target);
    endtask

    // Pulse (or hold) i_start, predict every strobe and the done pulse, then wait for completion.
    task automatic run_seq(input int d, input int pulses, input bit hold, input int spur_off);
        int l;
        int dn;
        int base;
        @(negedge clk);
        start[d] = 1'b1;
        l = cyc + 1;
        for (int p = 0; p < pulses; p++) begin
            push(d, 1'b0, 1'b0, l + 2 * p * resp_dly);
            push(d, 1'b0, 1'b1, l + (2 * p + 1) * resp_dly);
        end
        dn = l + 2 * pulses * resp_dly + SETTLE;
        push(d, 1'b1, 1'b1, dn);
        if (spur_off > 0) spur_at[d] = dn - SETTLE + spur_off;
        base = done_cnt[d];
        @(negedge clk);
        #1;
        check("busy_after_start", busy[d], 1);
        check("ready_cleared", ready[d], 0);
        check("error_cleared", err[d], 0);
        if (hold) begin
            while (cyc < dn) @(negedge clk);
        end
        start[d] = 1'b0;
        wait_done(d, base + 1);
        repeat (3) @(negedge clk);
        #1;
        check("ready_level", ready[d], 1);
        check("idle_after_done", busy[d], 0);
        check("single_done", done_cnt[d], base + 1);
        check("sb_drained", q.size(), 0);
    endtask

    // Responder: answers each strobe with a one-cycle i_reset_sent, sampled resp_dly edges later.
    initial begin : responder
        int due [2];
        due = '{-1, -1};
        sent = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sent[d] = (cyc == due[d]) || (cyc == spur_at[d]);
                if (ena[d] && resp_en) due[d] = cyc + resp_dly - 1;
            end
        end
    end

    initial begin : monitor
        bit  prev_ena  [2];
        bit  prev_done [2];
        bit  last_val  [2];
        ev_t e;
        prev_ena  = '{1'b0, 1'b0};
        prev_done = '{1'b0, 1'b0};
        last_val  = '{1'b1, 1'b1};
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (ena[d] === 1'b1) begin
                    check("ena_single", prev_ena[d], 0);
                    check("sb_has_strobe", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("strobe_dut", d, e.dut);
                        check("strobe_kind", e.is_done, 0);
                        check("strobe_cycle", cyc, e.cyc);
                        check("strobe_val", val[d], e.val);
                        last_val[d] = e.val;
                    end
                end else if (busy[d] === 1'b1) begin
                    check("val_hold", val[d], last_val[d]);
                end else begin
                    check("val_idle", val[d], 1);
                end
                if (done[d] === 1'b1) begin
                    check("done_single", prev_done[d], 0);
                    check("ready_with_done", ready[d], 1);
                    check("sb_has_done", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("done_dut", d, e.dut);
                        check("done_kind", e.is_done, 1);
                        check("done_cycle", cyc, e.cyc);
                    end
                    done_cnt[d]++;
                end
                prev_ena[d]  = ena[d];
                prev_done[d] = done[d];
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int l;
        start = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ena", ena[d], 0);
            check("rst_val", val[d], 1);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_ready", ready[d], 0);
            check("rst_error", err[d], 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic single-pair sequence.
        run_seq(0, 1, 1'b0, 0);

        // Two pairs: four strobes 0,1,0,1 and one done.
        run_seq(1, 2, 1'b0, 0);

        // i_start held through the sequence plus a stray completion pulse during SETTLE.
        run_seq(0, 1, 1'b1, 3);

        // Reset asserted while waiting for the low-request completion.
        @(negedge clk);
        start[0] = 1'b1;
        l = cyc + 1;
        push(0, 1'b0, 1'b0, l);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ena", ena[0], 0);
        check("midrst_val", val[0], 1);
        check("midrst_busy", busy[0], 0);
        check("midrst_ready", ready[0], 0);
        check("midrst_done", done[0], 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("idle_after_rst", busy[0], 0);
        check("ready_after_rst", ready[0], 0);
        check("sb_after_rst", q.size(), 0);

        // Sequence after reset release still works.
        run_seq(0, 1, 1'b0, 0);

`ifdef RST_SEQ_TIMEOUT_EN
        // Silent responder: ERROR after exactly TIMEOUT cycles in WAIT_LOW.
        resp_en = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        l = cyc + 1;
        push(0, 1'b0, 1'b0, l);
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < l + TIMEOUT) @(negedge clk);
        #1;
        check("wd_not_early", err[0], 0);
        check("wd_busy_before", busy[0], 1);
        @(negedge clk);
        #1;
        check("wd_error", err[0], 1);
        check("wd_error_val", val[0], 1);
        check("wd_error_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        #1;
        check("wd_error_held", err[0], 1);
        resp_en = 1'b1;
        run_seq(0, 1, 1'b0, 0);

        // Completion arriving in the expiry cycle wins over the watchdog.
        resp_dly = TIMEOUT + 1;
        run_seq(0, 1, 1'b0, 0);
        check("wd_boundary_no_error", err[0], 0);
        resp_dly = 5;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
